serial_word_deser: RTL

Serial-to-parallel collector sitting directly downstream of the team's 4-state Mealy sequence FSM. It samples that FSM's 1-bit output stream and packs successive bits into WIDTH-bit words, tracking the number of 1s in each word. It presents each completed word on a valid/ready output port with a single holding register and a sticky overrun flag. Its consumers are the word-level checkers and loggers further down the path.

---
 rtl/serial_word_deser.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word collector: packs accepted din bits MSB-first into
// WIDTH-bit words with a ones count, presented through a one-entry valid/ready holding register.
module serial_word_deser #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    ones_cnt,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg;
    logic [BW-1:0]    bcnt_reg;
    logic [CW-1:0]    pcnt_reg;
    logic [WIDTH-1:0] dout_reg;
    logic [CW-1:0]    ones_reg;
    logic             overrun_reg;

    logic             accept;
    logic             complete;
    logic             load;
    logic             drop;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    word_ones;

    // clr takes priority over en, so a cleared edge never completes a word
    assign accept    = en & ~clr;
    assign complete  = accept && (bcnt_reg == BW'(WIDTH - 1));
    assign word      = {sr_reg[WIDTH-2:0], din};
    assign word_ones = pcnt_reg + CW'(din);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg   <= '0;
            bcnt_reg <= '0;
            pcnt_reg <= '0;
        end else if (clr) begin
            sr_reg   <= '0;
            bcnt_reg <= '0;
            pcnt_reg <= '0;
        end else if (accept) begin
            if (complete) begin
                sr_reg   <= '0;
                bcnt_reg <= '0;
                pcnt_reg <= '0;
            end else begin
                sr_reg   <= word;
                bcnt_reg <= bcnt_reg + BW'(1);
                pcnt_reg <= word_ones;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    // a same-edge drain frees the slot for the new word
                    if (dout_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (dout_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= EMPTY;
            dout_reg    <= '0;
            ones_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                dout_reg <= word;
                ones_reg <= word_ones;
            end
            if (clr) begin
                overrun_reg <= 1'b0;
            end else if (drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign dout       = dout_reg;
    assign ones_cnt   = ones_reg;
    assign dout_valid = (state_reg == FULL);
    assign overrun    = overrun_reg;

endmodule
